// File: rtl/stream_filter_pkg.sv
// Shared constants and FSM encoding for the stream_filter configuration sequencer.
package stream_filter_pkg;

    localparam int CFG_WIDTH   = 1;
    localparam int CFG_KERNEL  = 2;
    localparam int CFG_RESCALE = 3;

    localparam int REG_WIDTH   = 0;
    localparam int REG_KER0    = 1;
    localparam int REG_RESCALE = 10;

    localparam int KER_NB      = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WIDTH,
        ST_KER,
        ST_RESC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cfg_shadow.sv
// Shadow register file: width, nine kernel taps and rescale, writable only while unlocked.
module cfg_shadow
    import stream_filter_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int MEM_AWIDTH = 12,
    parameter int KER_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            reg_addr,
    input  logic [CFG_DWIDTH-1:0] reg_data,
    input  logic                  reg_wr,
    input  logic                  lock,
    input  logic [3:0]            idx,
    output logic [MEM_AWIDTH-1:0] width,
    output logic [KER_WIDTH-1:0]  ker,
    output logic [15:0]           rescale
);

    logic [KER_WIDTH-1:0] k [KER_NB];
    logic                 unused_hi;

    assign unused_hi = ^reg_data[CFG_DWIDTH-1:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width   <= '0;
            rescale <= '0;
            for (int i = 0; i < KER_NB; i++) k[i] <= '0;
        end else if (reg_wr && !lock) begin
            if (reg_addr == 4'(REG_WIDTH))   width   <= reg_data[MEM_AWIDTH-1:0];
            if (reg_addr == 4'(REG_RESCALE)) rescale <= reg_data[15:0];
            for (int i = 0; i < KER_NB; i++) begin
                if (reg_addr == 4'(REG_KER0 + i)) k[i] <= reg_data[KER_WIDTH-1:0];
            end
        end
    end

    // Out-of-range idx reads as zero.
    always_comb begin
        ker = '0;
        for (int i = 0; i < KER_NB; i++) begin
            if (idx == 4'(i)) ker = k[i];
        end
    end

endmodule

// File: rtl/stream_filter_cfg_seq.sv
// Gates the pixel stream, drains the filter, then issues the 11-write cfg burst.
// All outputs are registered; the cfg burst is gap-free and never overlaps done.
module stream_filter_cfg_seq
    import stream_filter_pkg::*;
#(
    parameter int CFG_DWIDTH   = 32,
    parameter int CFG_AWIDTH   = 5,
    parameter int MEM_AWIDTH   = 12,
    parameter int IMG_WIDTH    = 16,
    parameter int KER_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            reg_addr,
    input  logic [CFG_DWIDTH-1:0] reg_data,
    input  logic                  reg_wr,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  configured,
    input  logic [IMG_WIDTH-1:0]  up_image,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [IMG_WIDTH-1:0]  dn_image,
    output logic                  dn_val,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            idx;
    logic [MEM_AWIDTH-1:0] sh_width;
    logic [KER_WIDTH-1:0]  sh_ker;
    logic [15:0]           sh_rescale;

    cfg_shadow #(
        .CFG_DWIDTH (CFG_DWIDTH),
        .MEM_AWIDTH (MEM_AWIDTH),
        .KER_WIDTH  (KER_WIDTH)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .reg_wr   (reg_wr),
        .lock     (busy),
        .idx      (idx),
        .width    (sh_width),
        .ker      (sh_ker),
        .rescale  (sh_rescale)
    );

    // idx points at the tap to load next, one ahead of the tap on cfg_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            configured <= 1'b0;
            up_rdy     <= 1'b0;
            cfg_valid  <= 1'b0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
        end else begin
            cfg_valid <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_DRAIN;
                        cnt    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        up_rdy <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state     <= ST_WIDTH;
                        cfg_valid <= 1'b1;
                        cfg_addr  <= CFG_AWIDTH'(CFG_WIDTH);
                        cfg_data  <= CFG_DWIDTH'(sh_width);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WIDTH: begin
                    state     <= ST_KER;
                    cfg_valid <= 1'b1;
                    cfg_addr  <= CFG_AWIDTH'(CFG_KERNEL);
                    cfg_data  <= CFG_DWIDTH'(sh_ker);
                    idx       <= idx + 4'd1;
                end
                ST_KER: begin
                    cfg_valid <= 1'b1;
                    if (idx == 4'(KER_NB)) begin
                        state    <= ST_RESC;
                        cfg_addr <= CFG_AWIDTH'(CFG_RESCALE);
                        cfg_data <= CFG_DWIDTH'(sh_rescale);
                    end else begin
                        cfg_addr <= CFG_AWIDTH'(CFG_KERNEL);
                        cfg_data <= CFG_DWIDTH'(sh_ker);
                        idx      <= idx + 4'd1;
                    end
                end
                ST_RESC: begin
                    state      <= ST_DONE;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    up_rdy     <= 1'b1;
                    configured <= 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_val   <= 1'b0;
            dn_image <= '0;
        end else begin
            dn_val <= up_val & up_rdy;
            if (up_val && up_rdy) dn_image <= up_image;
        end
    end

endmodule

// File: tb/tb_stream_filter_cfg_seq.sv
// Scoreboard bench: expected cfg writes and pixels are queued at stimulus time, popped on DUT output.
module tb_stream_filter_cfg_seq;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  reg_addr = '0;
    logic [31:0] reg_data = '0;
    logic        reg_wr = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, configured;
    logic [15:0] up_image = '0;
    logic        up_val = 1'b0;
    logic        up_rdy;
    logic [15:0] dn_image;
    logic        dn_val;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;

    stream_filter_cfg_seq #(
        .CFG_DWIDTH (32), .CFG_AWIDTH (5), .MEM_AWIDTH (12),
        .IMG_WIDTH (16), .KER_WIDTH (16), .DRAIN_CYCLES (D)
    ) dut (
        .clk (clk), .rst (rst), .reg_addr (reg_addr), .reg_data (reg_data),
        .reg_wr (reg_wr), .start (start), .busy (busy), .done (done),
        .configured (configured), .up_image (up_image), .up_val (up_val),
        .up_rdy (up_rdy), .dn_image (dn_image), .dn_val (dn_val),
        .cfg_data (cfg_data), .cfg_addr (cfg_addr), .cfg_valid (cfg_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        cfg_q[$];
    logic [15:0] pix_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_done = -1;
    bit          got_done = 0;
    bit          stream_on = 0;
    logic [15:0] ramp = 16'h0100;
    logic [31:0] m_width;
    logic [31:0] m_k [9];
    logic [31:0] m_resc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_width = '0;
        m_resc  = '0;
        for (int i = 0; i < 9; i++) m_k[i] = '0;
    endtask

    task automatic model_apply(input logic [3:0] a, input logic [31:0] d);
        if (a == 4'd0) m_width = d & 32'hFFF;
        else if (a >= 4'd1 && a <= 4'd9) m_k[a - 4'd1] = d & 32'hFFFF;
        else if (a == 4'd10) m_resc = d & 32'hFFFF;
    endtask

    task automatic monitor();
        exp_t e;
        if (cfg_valid) begin
            if (cfg_q.size() == 0) begin
                check("cfg_unexpected", 32'(cfg_addr), 32'hFFFF_FFFF);
            end else begin
                e = cfg_q.pop_front();
                check("cfg_cycle", cyc, e.cyc);
                check("cfg_addr", 32'(cfg_addr), 32'(e.addr));
                check("cfg_data", cfg_data, e.data);
            end
        end
        if (dn_val) begin
            if (pix_q.size() == 0) check("dn_unexpected", 32'(dn_image), 32'hFFFF_FFFF);
            else check("dn_image", 32'(dn_image), 32'(pix_q.pop_front()));
        end
        if (done) begin
            got_done = 1;
            check("done_cycle", cyc, exp_done);
            check("done_vs_cfg", 32'(cfg_valid), 0);
            check("done_busy", 32'(busy), 0);
            check("done_up_rdy", 32'(up_rdy), 1);
            check("done_configured", 32'(configured), 1);
        end
    endtask

    task automatic tick();
        bit acc;
        acc = up_val && up_rdy;
        if (acc) pix_q.push_back(up_image);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
        if (stream_on) begin
            if (acc) ramp++;
            up_val   = 1'b1;
            up_image = ramp;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit apply);
        reg_wr = 1'b1; reg_addr = a; reg_data = d;
        if (apply) model_apply(a, d);
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic start_seq(input bit with_wr, input logic [3:0] a, input logic [31:0] d);
        int t;
        t = cyc;
        if (with_wr) begin
            reg_wr = 1'b1; reg_addr = a; reg_data = d;
            model_apply(a, d);
        end
        cfg_q.push_back('{t + D + 1, 5'd1, m_width});
        for (int i = 0; i < 9; i++) cfg_q.push_back('{t + D + 2 + i, 5'd2, m_k[i]});
        cfg_q.push_back('{t + D + 11, 5'd3, m_resc});
        exp_done = t + D + 12;
        got_done = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        reg_wr = 1'b0;
        check("busy_rise", 32'(busy), 1);
        check("up_rdy_fall", 32'(up_rdy), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !got_done; i++) tick();
        check("done_seen", 32'(got_done), 1);
        check("cfg_q_drained", cfg_q.size(), 0);
    endtask

    task automatic load_regs(input logic [31:0] w, input logic [31:0] kbase, input logic [31:0] resc);
        wr(4'd0, w, 1);
        for (int i = 0; i < 9; i++) wr(4'(i + 1), kbase + 32'(i), 1);
        wr(4'd10, resc, 1);
        wr(4'd12, 32'hDEAD, 1);
    endtask

    initial begin
        int t;
        model_clear();
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_configured", 32'(configured), 0);
        check("rst_up_rdy", 32'(up_rdy), 0);
        check("rst_dn_val", 32'(dn_val), 0);
        check("rst_dn_image", 32'(dn_image), 0);
        check("rst_cfg_valid", 32'(cfg_valid), 0);
        check("rst_cfg_addr", 32'(cfg_addr), 0);
        check("rst_cfg_data", cfg_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset, pixels must not pass
        up_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            up_image = 16'(i);
            tick();
            check("idle_up_rdy", 32'(up_rdy), 0);
            check("idle_dn_val", 32'(dn_val), 0);
            check("idle_cfg_valid", 32'(cfg_valid), 0);
            check("idle_configured", 32'(configured), 0);
        end
        up_val = 1'b0;

        // 2: basic sequence
        load_regs(32'd640, 32'd1, 32'h0304);
        start_seq(0, 4'd0, 32'd0);
        wait_done();
        tick();
        check("post_up_rdy", 32'(up_rdy), 1);
        check("post_busy", 32'(busy), 0);

        // 3: write and start while busy are both ignored
        t = cyc;
        start_seq(0, 4'd0, 32'd0);
        while (cyc < t + 9) tick();
        start = 1'b1;
        wr(4'd4, 32'h7FFF, 0);
        start = 1'b0;
        wait_done();
        tick();
        start_seq(0, 4'd0, 32'd0);
        wait_done();
        tick();

        // 4: write in the same cycle as start
        start_seq(1, 4'd0, 32'd320);
        wait_done();
        tick();

        // 5: stream gating around a sequence with continuous ramp input
        stream_on = 1;
        up_val = 1'b1;
        up_image = ramp;
        for (int i = 0; i < 6; i++) tick();
        t = cyc;
        start_seq(0, 4'd0, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            check("gate_dn_val", 32'(dn_val), (k >= 2 && k <= D + 12) ? 32'd0 : 32'd1);
            tick();
        end
        check("gate_done_seen", 32'(got_done), 1);
        stream_on = 0;
        up_val = 1'b0;
        tick();
        tick();
        check("pix_q_drained", pix_q.size(), 0);

        // 6: async reset during the 5th kernel write
        t = cyc;
        start_seq(0, 4'd0, 32'd0);
        while (cyc < t + D + 6) tick();
        check("abort_cfg_valid_pre", 32'(cfg_valid), 1);
        cfg_q.delete();
        exp_done = -1;
        got_done = 0;
        #2 rst = 1'b1;
        #1;
        check("abort_cfg_valid", 32'(cfg_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_configured", 32'(configured), 0);
        check("abort_cfg_addr", 32'(cfg_addr), 0);
        #1 rst = 1'b0;
        model_clear();
        tick();
        check("after_rst_up_rdy", 32'(up_rdy), 0);
        load_regs(32'd1920, 32'h0A00, 32'h0812);
        start_seq(0, 4'd0, 32'd0);
        wait_done();
        tick();
        check("final_configured", 32'(configured), 1);
        check("final_cfg_q", cfg_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_filter_cfg_seq.md
Name: stream_filter_cfg_seq

Overview:
Configuration sequencer placed in front of stream_filter. A host loads shadow registers (line width, nine 3x3 kernel coefficients, rescale shift/head) and pulses start. The block then gates the image stream, waits for the filter pipeline to drain, and issues the ordered cfg_data/cfg_addr/cfg_valid write burst. It reopens the stream only once configuration has completed.

Parameters:
CFG_DWIDTH, 32, width of cfg_data and reg_data
CFG_AWIDTH, 5, width of cfg_addr
MEM_AWIDTH, 12, width of the line-width field
IMG_WIDTH, 16, pixel width
KER_WIDTH, 16, kernel coefficient width
DRAIN_CYCLES, 64, idle cycles between gating the stream and the first cfg write; must be at least 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
reg_addr  in  4  shadow register index
reg_data  in  CFG_DWIDTH  shadow write data
reg_wr  in  1  shadow write strobe
start  in  1  single-cycle request to run the configuration sequence
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the sequence completes
configured  out  1  high once at least one sequence has completed since reset
up_image  in  IMG_WIDTH  host pixel
up_val  in  1  host pixel valid
up_rdy  out  1  host may present pixels
dn_image  out  IMG_WIDTH  pixel to stream_filter image
dn_val  out  1  pixel valid to stream_filter image_val
cfg_data  out  CFG_DWIDTH  to stream_filter cfg_data
cfg_addr  out  CFG_AWIDTH  to stream_filter cfg_addr
cfg_valid  out  1  to stream_filter cfg_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: every output is 0, including up_rdy, configured, all shadow registers, the FSM (IDLE) and all counters.
- Reset asserted mid-sequence drops cfg_valid and busy immediately and clears configured. No partial burst resumes.
- Shadow register map:
  - index 0: width, reg_data[MEM_AWIDTH-1:0]
  - indices 1..9: kernel k0..k8, reg_data[KER_WIDTH-1:0]
  - index 10: rescale {shift[15:8], head[7:0]}
  - indices 11..15: writes ignored
- Shadow writes when busy=0 take effect on the next edge. Writes while busy=1 are ignored.
- A write in the same cycle as start is applied, and the sequence uses the new value.
- start is honoured only in IDLE. start while busy is dropped with no queueing.
- FSM states:
  - IDLE: on start, go to DRAIN at edge T. busy=1 and up_rdy=0 from T+1.
  - DRAIN: counter runs DRAIN_CYCLES cycles (T+1..T+D), then go to WIDTH.
  - WIDTH: one cycle, cfg_valid=1, cfg_addr=1, cfg_data=width zero-extended.
  - KER: nine consecutive cycles, cfg_addr=2, cfg_data=k[idx] zero-extended, idx 0..8 ascending. idx resets to 0 on KER entry.
  - RESC: one cycle, cfg_addr=3, cfg_data={zeros, shift, head}.
  - DONE: one cycle. done=1, busy=0, up_rdy=1, configured=1, then go to IDLE.
- Timing: first cfg write at T+D+1, last at T+D+11, done at T+D+12. The burst is gap-free, 11 writes total.
- cfg_valid, cfg_addr and cfg_data are registered. cfg_addr and cfg_data are 0 whenever cfg_valid=0.
- Stream gating:
  - up_rdy = configured & ~busy, registered.
  - dn_image <= up_image; dn_val <= up_val & up_rdy, giving one-cycle latency.
  - dn_image holds its last value when dn_val=0.
  - A pixel presented when up_rdy=0 is dropped; the host must honour up_rdy.
- Pixels accepted in the same cycle that start is sampled still pass through, because up_rdy falls one cycle later. The drain window covers them.
- done and cfg_valid are never high in the same cycle.

Decomposition:
- stream_filter_pkg holds:
  - cfg addresses CFG_WIDTH=1, CFG_KERNEL=2, CFG_RESCALE=3
  - shadow indices REG_WIDTH=0, REG_KER0=1, REG_RESCALE=10
  - KER_NB=9
  - the FSM state encoding
- One natural sub-module: cfg_shadow, the 11-entry register file with write gating and a kernel read mux indexed by idx. The FSM, drain counter and gating stay in the top.

Test Plan:
1. Reset then idle: rst pulse, no start, up_val=1 for 20 cycles -> up_rdy=0, dn_val=0, cfg_valid=0, configured=0 throughout.
2. Basic sequence, DRAIN_CYCLES=4: write width=640, k0..k8=1..9, rescale=0x0304, start at T -> cfg_valid high T+5..T+15 with addr/data (1,640), (2,1)..(2,9), (3,0x0304); done=1 at T+16; up_rdy=1 from T+16.
3. Write during busy: mid-burst write k3=0x7FFF, then a second start -> second burst still emits k3=4.
4. Same-cycle write and start: reg_wr index 0 data 320 together with start -> first cfg write carries 320.
5. Stream gating: configured, continuous up_val with ramp data, start at T -> dn_val high through T+1 (pixel accepted at T), low from T+2 until T+16, ramp resumes at T+17 with no duplicated pixels.
6. Async reset at the 5th kernel write -> cfg_valid and busy go low without a clock edge, configured=0; a new start replays the full 11-write burst from WIDTH.
